// File: rtl/addsub_pkg.sv
// Shared types and constants for the shared add/sub arbiter (default 16-bit, 4-requester configuration).
// Optional saturation is selected by the ADDSUB_ARB_SAT_EN macro in addsub_arbiter.
package addsub_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ID_W    = 2;

    localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] sum;
        logic                  cout;
        logic                  ovfl;
        logic [DEF_ID_W-1:0]   id;
    } rsp_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/sub built from 4-bit carry-lookahead groups; latency 0, no state.
// No backpressure of its own: the arbiter decides when a result is captured.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o,
    output logic              ovfl_o
);

    localparam int NG = DATA_W / 4;

    logic [DATA_W-1:0] beff;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] c;
    logic [NG-1:0]     gp;
    logic [NG-1:0]     gg;
    logic [NG:0]       cg;

    assign beff = sub_i ? ~b_i : b_i;
    assign p    = a_i ^ beff;
    assign g    = a_i & beff;

    always_comb begin
        c  = '0;
        gp = '0;
        gg = '0;
        cg = '0;
        // Subtract is A + ~B + 1, so the forced carry-in replaces cin.
        cg[0] = sub_i | cin_i;
        for (int k = 0; k < NG; k++) begin
            gp[k]      = &p[4*k +: 4];
            gg[k]      = g[4*k+3]
                       | (p[4*k+3] & g[4*k+2])
                       | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                       | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            c[4*k]     = cg[k];
            c[4*k+1]   = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2]   = g[4*k+1]
                       | (p[4*k+1] & g[4*k])
                       | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3]   = g[4*k+2]
                       | (p[4*k+2] & g[4*k+1])
                       | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
            cg[k+1]    = gg[k] | (gp[k] & cg[k]);
        end
    end

    assign sum_o  = p ^ c;
    assign cout_o = cg[NG];
    assign ovfl_o = (a_i[DATA_W-1] == beff[DATA_W-1]) & (sum_o[DATA_W-1] != a_i[DATA_W-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin share of one add/sub core across NUM_REQ requesters; 1-cycle accept-to-result latency.
// Backpressure: all req_ready drop while a held result is stalled; ADDSUB_ARB_SAT_EN clamps overflowed sums.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_ovfl,
    output logic [ID_W-1:0]           rsp_id
);

    if (ID_W != $clog2(NUM_REQ)) begin : g_chk_id_w
        $error("addsub_arbiter: ID_W must equal clog2(NUM_REQ)");
    end
    if ((DATA_W % 4) != 0) begin : g_chk_data_w
        $error("addsub_arbiter: DATA_W must be a multiple of 4");
    end
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_chk_num_req
        $error("addsub_arbiter: NUM_REQ must be in 2..8");
    end

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              ovfl;
        logic [ID_W-1:0]   id;
    } rsp_slot_t;

    stage_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    rsp_slot_t         rsp_q, rsp_d;

    logic [ID_W-1:0]   win;
    logic              found;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              cin_sel;
    logic              sub_sel;
    logic [DATA_W-1:0] core_sum;
    logic              core_cout;
    logic              core_ovfl;
    logic [DATA_W-1:0] res_sum;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_q) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
    assign accept     = rst_n & found & can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    assign a_sel   = req_a[int'(win)*DATA_W +: DATA_W];
    assign b_sel   = req_b[int'(win)*DATA_W +: DATA_W];
    assign cin_sel = req_cin[win];
    assign sub_sel = req_sub[win];

    addsub_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a_i    (a_sel),
        .b_i    (b_sel),
        .cin_i  (cin_sel),
        .sub_i  (sub_sel),
        .sum_o  (core_sum),
        .cout_o (core_cout),
        .ovfl_o (core_ovfl)
    );

`ifdef ADDSUB_ARB_SAT_EN
    localparam logic [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};

    // Overflow direction follows the sign of A: positive A can only overflow upward.
    assign res_sum = core_ovfl ? (a_sel[DATA_W-1] ? SAT_LO : SAT_HI) : core_sum;
`else
    assign res_sum = core_sum;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        rsp_d   = rsp_q;
        if (accept) begin
            state_d    = ST_FULL;
            rr_d       = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            rsp_d.sum  = res_sum;
            rsp_d.cout = core_cout;
            rsp_d.ovfl = core_ovfl;
            rsp_d.id   = win;
        end else if (rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            rr_q    <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_sum   = rsp_q.sum;
    assign rsp_cout  = rsp_q.cout;
    assign rsp_ovfl  = rsp_q.ovfl;
    assign rsp_id    = rsp_q.id;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed plus random bench for addsub_arbiter against an arithmetic/round-robin reference model.
// Expected saturation behaviour follows ADDSUB_ARB_SAT_EN.
module tb_addsub_arbiter;
    import addsub_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovfl;
    logic [1:0]     rsp_id;

    int checks   = 0;
    int failures = 0;

    int           m_ptr;
    logic         m_full;
    rsp_t         m_rsp;
    logic [N-1:0] last_acc;

    addsub_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovfl  (rsp_ovfl),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub);
        req_a[p*W +: W] = a;
        req_b[p*W +: W] = b;
        req_cin[p]      = cin;
        req_sub[p]      = sub;
    endtask

    task automatic rand_port(input int p);
        logic [15:0] b;
        case ($urandom_range(0, 5))
            0:       b = 16'h8000;
            1:       b = 16'h7FFF;
            2:       b = 16'hFFFF;
            default: b = 16'($urandom);
        endcase
        set_port(p, 16'($urandom), b, 1'($urandom), 1'($urandom));
    endtask

    task automatic model_reset();
        m_full   = 1'b0;
        m_ptr    = 0;
        m_rsp    = '0;
        last_acc = '0;
    endtask

    // Round-robin choice: first valid port counting up from the pointer.
    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // Integer-arithmetic view of the operation: unsigned sum for carry, signed sum for overflow.
    function automatic rsp_t model_op(input int p);
        rsp_t        r;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] beff;
        logic        c0;
        int unsigned u;
        int          s;
        a    = req_a[p*W +: W];
        b    = req_b[p*W +: W];
        beff = req_sub[p] ? ~b : b;
        c0   = req_sub[p] ? 1'b1 : req_cin[p];
        u    = 32'(a) + 32'(beff) + 32'(c0);
        s    = int'($signed(a)) + int'($signed(beff)) + int'(c0);
        r.sum  = u[15:0];
        r.cout = u[16];
        r.ovfl = (s > 32767) || (s < -32768);
`ifdef ADDSUB_ARB_SAT_EN
        if (r.ovfl) r.sum = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        r.id = 2'(p);
        return r;
    endfunction

    // One clock: compare mid-low-phase, advance the model at the edge, return at the next falling edge.
    task automatic step(input string tag);
        int           w;
        logic [N-1:0] exp_rdy;
        #2;
        w       = pick();
        exp_rdy = '0;
        if (rst_n && (w >= 0) && (!m_full || rsp_ready)) exp_rdy[w] = 1'b1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_full));
        check({tag, ".rsp_sum"},   32'(rsp_sum),   32'(m_rsp.sum));
        check({tag, ".rsp_cout"},  32'(rsp_cout),  32'(m_rsp.cout));
        check({tag, ".rsp_ovfl"},  32'(rsp_ovfl),  32'(m_rsp.ovfl));
        check({tag, ".rsp_id"},    32'(rsp_id),    32'(m_rsp.id));
        last_acc = exp_rdy;
        @(posedge clk);
        if (rst_n) begin
            if (exp_rdy != '0) begin
                m_rsp  = model_op(w);
                m_full = 1'b1;
                m_ptr  = (w + 1) % N;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        for (int p = 0; p < N; p++) rand_port(p);
        model_reset();

        // Held in reset with every port requesting: nothing may be granted.
        step("in_reset0");
        step("in_reset1");

        rst_n     = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 10; k++) step("idle");

        // Port 2 add with carry-in.
        set_port(2, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
        req_valid = 4'b0100;
        step("p2_add");
        req_valid = '0;
        check("p2_add.valid", 32'(rsp_valid), 32'd1);
        check("p2_add.sum",   32'(rsp_sum),   32'h2144);
        check("p2_add.cout",  32'(rsp_cout),  32'd0);
        check("p2_add.ovfl",  32'(rsp_ovfl),  32'd0);
        check("p2_add.id",    32'(rsp_id),    32'd2);
        step("p2_drain");

        // Port 0: 0 - 0x8000 overflows positive.
        set_port(0, 16'h0000, 16'h8000, 1'b1, 1'b1);
        req_valid = 4'b0001;
        step("p0_sub");
        req_valid = '0;
`ifdef ADDSUB_ARB_SAT_EN
        check("p0_sub.sum",  32'(rsp_sum),  32'h7FFF);
`else
        check("p0_sub.sum",  32'(rsp_sum),  32'h8000);
`endif
        check("p0_sub.ovfl", 32'(rsp_ovfl), 32'd1);
        check("p0_sub.cout", 32'(rsp_cout), 32'd0);
        check("p0_sub.id",   32'(rsp_id),   32'd0);
        step("p0_drain");

        // All ports valid with a free-running consumer: one grant per cycle, rotating from port 1.
        for (int p = 0; p < N; p++) rand_port(p);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step("rr");
            check("rr.seq_id", 32'(rsp_id), 32'((1 + k) % N));
        end

        // Stalled consumer: grants blocked and the held result stable.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step("stall");
            check("stall.id_held", 32'(rsp_id), 32'd0);
        end
        rsp_ready = 1'b1;
        step("drain_acc");
        check("drain_acc.valid", 32'(rsp_valid), 32'd1);
        check("drain_acc.id",    32'(rsp_id),    32'd1);

        // Asynchronous reset with a result pending.
        rsp_ready = 1'b0;
        step("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst.req_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        step("arst_hold");
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        step("post_rst");
        check("post_rst.id", 32'(rsp_id), 32'd1);

        // Random traffic with held payloads, occasional withdrawals and random stalls.
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_valid[p] || last_acc[p]) begin
                    req_valid[p] = 1'($urandom);
                    rand_port(p);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[p] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        step("tail0");
        step("tail1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 16-bit carry-lookahead add/sub unit between NUM_REQ requesters (ALU, branch-target calc, address gen, debug port).
- Round-robin grant, valid/ready handshake on each request port and on the single response port.
- One-deep registered result stage gives 1-cycle latency and full throughput when the response side is not stalled.
- Sits between issue logic and writeback in the processor datapath.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
DATA_W, 16, operand/result width; must be a multiple of 4 (4-bit CLA groups)
ID_W, 2, requester-index width; must equal clog2(NUM_REQ), checked by elaboration assertion

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept
req_a  input  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  input  NUM_REQ*DATA_W  operand B, same packing
req_cin  input  NUM_REQ  carry-in; used for add only
req_sub  input  NUM_REQ  1 = A-B, 0 = A+B+cin
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_sum  output  DATA_W  result
rsp_cout  output  1  carry out of the MSB
rsp_ovfl  output  1  signed overflow
rsp_id  output  ID_W  index of the requester that owns the result

Behaviour:
- Reset (async assert, sync deassert):
  - rsp_valid=0; rsp_sum, rsp_cout, rsp_ovfl, rsp_id = 0.
  - rr_ptr=0.
  - req_ready=0 while rst_n is low.
- Stage state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
  - can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready[w]=1 only if can_accept and req_valid[w]; every other req_ready bit is 0.
  - req_ready never asserts without its own req_valid.
- Accept (req_valid[w] & req_ready[w] at a clock edge):
  - Compute through the add/sub core and register sum/cout/ovfl/id.
  - rsp_valid=1 on the next cycle.
  - rr_ptr <= (w+1) mod NUM_REQ.
- Without an accept: rr_ptr holds.
- Response handshake:
  - rsp_valid & rsp_ready with no new accept: go to EMPTY.
  - Simultaneous drain and accept: stay FULL with the new result (back-to-back, 1 result/cycle).
- FULL & !rsp_ready: all req_ready=0; the rsp_* outputs hold stable.
- Requester obligations:
  - Hold req_valid and the payload stable until accepted.
  - Dropping valid before acceptance is legal; that request is discarded.
- Arithmetic:
  - Beff = sub ? ~B : B; c0 = sub ? 1 : cin (cin is ignored on sub).
  - {cout, sum} = A + Beff + c0, modulo 2^DATA_W.
  - ovfl = (A[MSB]==Beff[MSB]) & (sum[MSB]!=A[MSB]).
  - A - 0x8000 with A >= 0 reports ovfl=1.
- Reset mid-operation: any pending result is discarded; no response is emitted after release.
- Latency from accept to rsp_valid: exactly 1 cycle.

Optional Feature:
- Macro ADDSUB_ARB_SAT_EN.
- Defined:
  - When ovfl=1, the registered rsp_sum is clamped: 0x7FFF if A[MSB]=0, 0x8000 if A[MSB]=1 (generalized to DATA_W).
  - rsp_ovfl is still reported and rsp_cout is unchanged.
- Undefined: rsp_sum is the wrapped result; there is no clamp logic.

Decomposition:
- Package addsub_pkg:
  - DATA_W default constant.
  - Response struct {sum, cout, ovfl, id}.
  - Saturation constants SAT_MAX/SAT_MIN.
- Sub-module addsub_core:
  - Purely combinational.
  - DATA_W/4 four-bit CLA groups with group P/G and lookahead carries.
  - Ports: A, B, cin, sub -> sum, cout, ovfl.
- The arbiter instantiates exactly one addsub_core.

Test Plan:
- Reset then idle, all req_valid=0 → rsp_valid=0, req_ready=0, rsp_* = 0 for 10 cycles.
- Single request on port 2: A=0x1234, B=0x0F0F, add, cin=1 → next cycle rsp_sum=0x2144, cout=0, ovfl=0, rsp_id=2.
- Subtract on port 0: A=0x0000, B=0x8000 → sum=0x8000, ovfl=1, cout=0.
  - With ADDSUB_ARB_SAT_EN: sum=0x7FFF.
- All 4 ports valid continuously, rsp_ready=1 → grants 0,1,2,3,0… one per cycle; rsp_id sequence matches; no port starved.
- rsp_ready=0 for 5 cycles while FULL → all req_ready=0 and rsp_* stable.
  - On rsp_ready=1: drain and new accept happen in the same cycle.
- Assert rst_n=0 mid-stream with a result pending → rsp_valid=0 immediately (asynchronous); rr_ptr=0 after release; the first grant goes to the lowest valid port.
